// File: rtl/ifm_window_reader.sv
// ifm_window_reader: scans KxK windows of one IFM bank, two output rows per pass.
// Optional IFM_READ_STALL_EN adds consumer_ready back-pressure on tap issue.
module ifm_window_reader #(
  parameter int DATA_WIDTH       = 32,
  parameter int IFM_SIZE         = 5,
  parameter int KERNEL_SIZE      = 3,
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE*IFM_SIZE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
`ifdef IFM_READ_STALL_EN
  input  logic                        consumer_ready,
`endif
  output logic [1:0]                  ifm_sel,
  output logic                        ifm_enable_read_A_next,
  output logic                        ifm_enable_read_B_next,
  output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_A_next,
  output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_B_next,
  output logic                        valid_A,
  output logic                        valid_B,
  output logic                        window_first,
  output logic                        window_last,
  output logic                        busy,
  output logic                        done
);

  localparam int OS = IFM_SIZE - KERNEL_SIZE + 1;
  localparam int RP = (OS + 1) / 2;
  localparam int CW = $clog2(IFM_SIZE + 1);

  if (DATA_WIDTH > 0) begin : g_dw
  end

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] rp, ocol, kr, kc;
  logic go, issue;
  logic kc_end, kr_end, oc_end, rp_end;
  logic last_tap, first_tap, b_on;
  logic [ADDRESS_SIZE_IFM-1:0] a_calc, b_calc;
  int row, col;

`ifdef IFM_READ_STALL_EN
  assign go = consumer_ready;
`else
  assign go = 1'b1;
`endif

  // tap position flags and the two row addresses for the current tap
  always_comb begin
    kc_end    = (kc == CW'(KERNEL_SIZE-1));
    kr_end    = (kr == CW'(KERNEL_SIZE-1));
    oc_end    = (ocol == CW'(OS-1));
    rp_end    = (rp == CW'(RP-1));
    last_tap  = kc_end && kr_end && oc_end && rp_end;
    first_tap = (kr == '0) && (kc == '0);
    b_on      = (2*int'(rp) + 1) < OS;
    row       = 2*int'(rp) + int'(kr);
    col       = int'(ocol) + int'(kc);
    a_calc    = ADDRESS_SIZE_IFM'(row*IFM_SIZE + col);
    b_calc    = ADDRESS_SIZE_IFM'((row+1)*IFM_SIZE + col);
  end

  // next state and tap outputs; buses stay 0 off-tap since the array ORs them
  always_comb begin
    state_d                 = state_q;
    busy                    = 1'b0;
    done                    = 1'b0;
    issue                   = 1'b0;
    ifm_enable_read_A_next  = 1'b0;
    ifm_enable_read_B_next  = 1'b0;
    ifm_address_read_A_next = '0;
    ifm_address_read_B_next = '0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = READ;
      end
      READ: begin
        busy = 1'b1;
        if (go) begin
          issue                   = 1'b1;
          ifm_enable_read_A_next  = 1'b1;
          ifm_address_read_A_next = a_calc;
          if (b_on) begin
            ifm_enable_read_B_next  = 1'b1;
            ifm_address_read_B_next = b_calc;
          end
          if (last_tap) state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // loop nest rp > ocol > kr > kc, wraps to zero after the final tap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rp   <= '0;
      ocol <= '0;
      kr   <= '0;
      kc   <= '0;
    end else if (issue) begin
      if (kc_end) begin
        kc <= '0;
        if (kr_end) begin
          kr <= '0;
          if (oc_end) begin
            ocol <= '0;
            rp   <= rp_end ? '0 : rp + 1'b1;
          end else begin
            ocol <= ocol + 1'b1;
          end
        end else begin
          kr <= kr + 1'b1;
        end
      end else begin
        kc <= kc + 1'b1;
      end
    end
  end

  // one-cycle array latency alignment of valids and window tags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_A      <= 1'b0;
      valid_B      <= 1'b0;
      window_first <= 1'b0;
      window_last  <= 1'b0;
    end else begin
      valid_A      <= ifm_enable_read_A_next;
      valid_B      <= ifm_enable_read_B_next;
      window_first <= issue && first_tap;
      window_last  <= issue && kc_end && kr_end;
    end
  end

  // bank rotation 0->1->2->0 when leaving DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                ifm_sel <= 2'd0;
    else if (state_q == DONE) ifm_sel <= (ifm_sel == 2'd2) ? 2'd0 : ifm_sel + 2'd1;
  end

endmodule

// File: tb/tb_ifm_window_reader.sv
// tb_ifm_window_reader: directed bench for ifm_window_reader.
// Define IFM_READ_STALL_EN to also exercise consumer_ready back-pressure.
module tb_ifm_window_reader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic start6 = 1'b0;
`ifdef IFM_READ_STALL_EN
  logic consumer_ready = 1'b1;
  logic cr6 = 1'b1;
`endif

  logic [1:0] ifm_sel;
  logic en_a, en_b;
  logic [4:0] addr_a, addr_b;
  logic valid_A, valid_B, window_first, window_last, busy, done;

  logic [1:0] sel6;
  logic en_a6, en_b6;
  logic [5:0] addr_a6, addr_b6;
  logic va6, vb6, wf6, wl6, busy6, done6;

  always #5 clk = ~clk;

  ifm_window_reader u_dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef IFM_READ_STALL_EN
    .consumer_ready(consumer_ready),
`endif
    .ifm_sel(ifm_sel),
    .ifm_enable_read_A_next(en_a), .ifm_enable_read_B_next(en_b),
    .ifm_address_read_A_next(addr_a), .ifm_address_read_B_next(addr_b),
    .valid_A(valid_A), .valid_B(valid_B),
    .window_first(window_first), .window_last(window_last),
    .busy(busy), .done(done)
  );

  ifm_window_reader #(.IFM_SIZE(6), .KERNEL_SIZE(3)) u_dut6 (
    .clk(clk), .reset(reset), .start(start6),
`ifdef IFM_READ_STALL_EN
    .consumer_ready(cr6),
`endif
    .ifm_sel(sel6),
    .ifm_enable_read_A_next(en_a6), .ifm_enable_read_B_next(en_b6),
    .ifm_address_read_A_next(addr_a6), .ifm_address_read_B_next(addr_b6),
    .valid_A(va6), .valid_B(vb6),
    .window_first(wf6), .window_last(wl6),
    .busy(busy6), .done(done6)
  );

  int n_checks = 0;
  int n_fail = 0;

  int busy_cnt, taps, btaps, done_cnt, wf_cnt, wl_cnt, va_cnt;
  int bad_idle, sel_moves, last_tap_cyc, wl_last_cyc, idle_en_cnt;
  logic [4:0] a_log [64];
  logic [4:0] b_log [64];
  logic       eb_log [64];
  logic [1:0] sel_before, sel_after;
  bit timeout;

  task automatic run_scan(input bit inject, input int stall_at, input int stall_len);
    int st;
    busy_cnt = 0; taps = 0; btaps = 0; done_cnt = 0; wf_cnt = 0;
    wl_cnt = 0; va_cnt = 0; bad_idle = 0; sel_moves = 0;
    last_tap_cyc = -1; wl_last_cyc = -2; idle_en_cnt = 0; st = 0;
    timeout = 1'b1;
    sel_before = ifm_sel;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
`ifdef IFM_READ_STALL_EN
      if (taps == stall_at - 1 && st < stall_len) begin
        consumer_ready = 1'b0;
        st++;
      end else begin
        consumer_ready = 1'b1;
      end
`else
      if (stall_at < 0 && stall_len < 0) st = 0;
`endif
      #1;
      if (!busy) begin
        timeout = 1'b0;
        break;
      end
      start = inject;
      busy_cnt++;
      if (ifm_sel !== sel_before) sel_moves++;
      if (done) done_cnt++;
      if (valid_A) va_cnt++;
      if (valid_A && window_first) wf_cnt++;
      if (valid_A && window_last) begin
        wl_cnt++;
        wl_last_cyc = cyc;
      end
      if (en_a) begin
        if (taps < 64) begin
          a_log[taps] = addr_a;
          b_log[taps] = addr_b;
          eb_log[taps] = en_b;
        end
        taps++;
        if (en_b) btaps++;
        last_tap_cyc = cyc;
      end else begin
        idle_en_cnt++;
        if (en_b || addr_a != 0 || addr_b != 0) bad_idle++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
`ifdef IFM_READ_STALL_EN
    consumer_ready = 1'b1;
`endif
    sel_after = ifm_sel;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({en_a, en_b, addr_a, addr_b, valid_A, valid_B, window_first,
         window_last, busy, done, ifm_sel} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0",
        {en_a, en_b, addr_a, addr_b, valid_A, valid_B, window_first,
         window_last, busy, done, ifm_sel});
    end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || en_a !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b en_a=%b required 0 0", busy, en_a);
    end
  endtask

  task automatic test_single_scan();
    run_scan(1'b0, 0, 0);
    n_checks++;
    if (timeout) begin n_fail++; $display("FAIL scan_timeout: busy never fell"); end
    n_checks++;
    if (busy_cnt != 56) begin n_fail++; $display("FAIL busy_cycles: got %0d required 56", busy_cnt); end
    n_checks++;
    if (taps != 54) begin n_fail++; $display("FAIL tap_count: got %0d required 54", taps); end
    n_checks++;
    if (btaps != 27) begin n_fail++; $display("FAIL b_taps: got %0d required 27", btaps); end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL done_pulses: got %0d required 1", done_cnt); end
    n_checks++;
    if ({a_log[0], a_log[1], a_log[2], a_log[3]} !== {5'd0, 5'd1, 5'd2, 5'd5}) begin
      n_fail++;
      $display("FAIL first_a: got %0d %0d %0d %0d required 0 1 2 5",
        a_log[0], a_log[1], a_log[2], a_log[3]);
    end
    n_checks++;
    if ({b_log[0], b_log[1], b_log[2], b_log[3]} !== {5'd5, 5'd6, 5'd7, 5'd10}) begin
      n_fail++;
      $display("FAIL first_b: got %0d %0d %0d %0d required 5 6 7 10",
        b_log[0], b_log[1], b_log[2], b_log[3]);
    end
    n_checks++;
    if (a_log[27] !== 5'd10 || eb_log[27] !== 1'b0 || b_log[27] !== 5'd0) begin
      n_fail++;
      $display("FAIL tap28: got A=%0d enB=%b B=%0d required A=10 enB=0 B=0",
        a_log[27], eb_log[27], b_log[27]);
    end
    n_checks++;
    if (a_log[53] !== 5'd24) begin n_fail++; $display("FAIL final_tap: got A=%0d required 24", a_log[53]); end
    n_checks++;
    if (wl_last_cyc != last_tap_cyc + 1) begin
      n_fail++;
      $display("FAIL last_tag_align: got cycle %0d required %0d", wl_last_cyc, last_tap_cyc + 1);
    end
    n_checks++;
    if (wf_cnt != 6 || wl_cnt != 6 || va_cnt != 54) begin
      n_fail++;
      $display("FAIL tag_counts: got first=%0d last=%0d validA=%0d required 6 6 54", wf_cnt, wl_cnt, va_cnt);
    end
    n_checks++;
    if (bad_idle != 0 || idle_en_cnt != 2) begin
      n_fail++;
      $display("FAIL idle_buses: got bad=%0d idle=%0d required 0 2", bad_idle, idle_en_cnt);
    end
    n_checks++;
    if (sel_before !== 2'd0 || sel_after !== 2'd1 || sel_moves != 0) begin
      n_fail++;
      $display("FAIL sel_rotate: got %0d->%0d moves=%0d required 0->1 moves=0",
        sel_before, sel_after, sel_moves);
    end
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    n_checks++;
    if (en_a !== 1'b1 || addr_a !== 5'd3) begin
      n_fail++;
      $display("FAIL tap20_addr: got en=%b A=%0d required 1 3", en_a, addr_a);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({en_a, en_b, addr_a, addr_b, valid_A, valid_B, window_first,
         window_last, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL midscan_reset: got %h required 0",
        {en_a, en_b, addr_a, addr_b, valid_A, valid_B, window_first,
         window_last, busy, done});
    end
    n_checks++;
    if (ifm_sel !== 2'd0) begin n_fail++; $display("FAIL midscan_sel: got %0d required 0", ifm_sel); end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || en_a !== 1'b0 || ifm_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL no_resume: got busy=%b en=%b sel=%0d required 0 0 0", busy, en_a, ifm_sel);
    end
    run_scan(1'b0, 0, 0);
    n_checks++;
    if (a_log[0] !== 5'd0 || taps != 54 || sel_after !== 2'd1) begin
      n_fail++;
      $display("FAIL rescan: got A0=%0d taps=%0d sel=%0d required 0 54 1", a_log[0], taps, sel_after);
    end
  endtask

  task automatic test_back_to_back();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      run_scan(1'b1, 0, 0);
      n_checks++;
      if (sel_before !== 2'(i) || sel_moves != 0) begin
        n_fail++;
        $display("FAIL b2b_sel scan %0d: got %0d moves=%0d required %0d", i, sel_before, sel_moves, i);
      end
      n_checks++;
      if (timeout || taps != 54 || busy_cnt != 56 || done_cnt != 1) begin
        n_fail++;
        $display("FAIL b2b_scan %0d: got taps=%0d busy=%0d done=%0d required 54 56 1",
          i, taps, busy_cnt, done_cnt);
      end
    end
    n_checks++;
    if (sel_after !== 2'd0) begin n_fail++; $display("FAIL b2b_wrap: got %0d required 0", sel_after); end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL start_ignored: busy=%b required 0", busy); end
  endtask

`ifdef IFM_READ_STALL_EN
  task automatic test_stall();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    run_scan(1'b0, 10, 3);
    n_checks++;
    if (timeout || busy_cnt != 59 || taps != 54) begin
      n_fail++;
      $display("FAIL stall_scan: got busy=%0d taps=%0d required 59 54", busy_cnt, taps);
    end
    n_checks++;
    if (idle_en_cnt != 5 || bad_idle != 0) begin
      n_fail++;
      $display("FAIL stall_idle: got idle=%0d bad=%0d required 5 0", idle_en_cnt, bad_idle);
    end
    n_checks++;
    if (a_log[9] !== 5'd1 || b_log[9] !== 5'd6 || a_log[10] !== 5'd2) begin
      n_fail++;
      $display("FAIL stall_reissue: got A=%0d B=%0d next=%0d required 1 6 2", a_log[9], b_log[9], a_log[10]);
    end
    n_checks++;
    if (va_cnt != 54 || wl_last_cyc != last_tap_cyc + 1) begin
      n_fail++;
      $display("FAIL stall_valid: got validA=%0d lastcyc=%0d required 54 %0d",
        va_cnt, wl_last_cyc, last_tap_cyc + 1);
    end
  endtask
`endif

  task automatic test_param6();
    int b6, t6, bt6;
    logic [5:0] la, lb;
    bit to6;
    b6 = 0; t6 = 0; bt6 = 0; la = '0; lb = '0; to6 = 1'b1;
    start6 = 1'b1;
    @(posedge clk); #1;
    start6 = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!busy6) begin
        to6 = 1'b0;
        break;
      end
      b6++;
      if (en_a6) begin
        t6++;
        if (en_b6) bt6++;
        la = addr_a6;
        lb = addr_b6;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (to6 || t6 != 72 || bt6 != 72 || b6 != 74) begin
      n_fail++;
      $display("FAIL size6_scan: got taps=%0d btaps=%0d busy=%0d required 72 72 74", t6, bt6, b6);
    end
    n_checks++;
    if (la !== 6'd29 || lb !== 6'd35) begin
      n_fail++;
      $display("FAIL size6_final: got A=%0d B=%0d required 29 35", la, lb);
    end
  endtask

  initial begin
    test_reset();
    test_single_scan();
    test_mid_reset();
    test_back_to_back();
`ifdef IFM_READ_STALL_EN
    test_stall();
`endif
    test_param6();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
